// File: rtl/wb_unit.sv
// wb_unit: writeback stage. ALU results pass straight to the register file
// write port; loads issue one aligned 64-bit read, then extract and extend
// the addressed lane. Also reports the held rd for hazard detection and a
// one-cycle commit pulse per retired instruction.
module wb_unit #(
   parameter int unsigned XLEN       = 64,
   parameter int unsigned ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [XLEN-1:0]       in_pc,
   input  logic [ADDR_WIDTH-1:0] in_rd,
   input  logic                  in_rd_wen,
   input  logic                  in_is_load,
   input  logic [2:0]            in_funct3,
   input  logic [XLEN-1:0]       in_result,
   output logic                  mem_req_valid,
   input  logic                  mem_req_ready,
   output logic [XLEN-1:0]       mem_addr,
   input  logic                  mem_resp_valid,
   input  logic [XLEN-1:0]       mem_resp_data,
   output logic                  rf_wen,
   output logic [ADDR_WIDTH-1:0] rf_waddr,
   output logic [XLEN-1:0]       rf_wdata,
   output logic                  pend_valid,
   output logic [ADDR_WIDTH-1:0] pend_rd,
   output logic                  commit_valid,
   output logic [XLEN-1:0]       commit_pc,
   output logic                  commit_err
);

   // Byte offset within a memory word and the matching bit-shift width.
   localparam int unsigned OFF_W   = 3;
   localparam int unsigned SHAMT_W = OFF_W + 3;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REQ   = 2'd1,
      S_WAIT  = 2'd2,
      S_WRITE = 2'd3
   } state_t;

   // State and captured instruction fields.
   state_t                r_state;
   logic [XLEN-1:0]       r_pc;
   logic [ADDR_WIDTH-1:0] r_rd;
   logic                  r_rd_wen;
   logic                  r_is_load;
   logic [2:0]            r_funct3;
   logic [XLEN-1:0]       r_result;
   logic [XLEN-1:0]       r_data;
   logic                  r_err;

   // Registered outputs.
   logic                  r_mem_req_valid;
   logic [XLEN-1:0]       r_mem_addr;
   logic                  r_rf_wen;
   logic [ADDR_WIDTH-1:0] r_rf_waddr;
   logic [XLEN-1:0]       r_rf_wdata;
   logic                  r_pend_valid;
   logic [ADDR_WIDTH-1:0] r_pend_rd;
   logic                  r_commit_valid;
   logic [XLEN-1:0]       r_commit_pc;
   logic                  r_commit_err;

   // Next-state values.
   state_t                w_next_state;
   logic [XLEN-1:0]       w_nx_pc;
   logic [ADDR_WIDTH-1:0] w_nx_rd;
   logic                  w_nx_rd_wen;
   logic                  w_nx_is_load;
   logic [2:0]            w_nx_funct3;
   logic [XLEN-1:0]       w_nx_result;
   logic [XLEN-1:0]       w_nx_data;
   logic                  w_nx_err;

   logic                  w_nx_mem_req_valid;
   logic [XLEN-1:0]       w_nx_mem_addr;
   logic                  w_nx_rf_wen;
   logic [ADDR_WIDTH-1:0] w_nx_rf_waddr;
   logic [XLEN-1:0]       w_nx_rf_wdata;
   logic                  w_nx_pend_valid;
   logic [ADDR_WIDTH-1:0] w_nx_pend_rd;
   logic                  w_nx_commit_valid;
   logic [XLEN-1:0]       w_nx_commit_pc;
   logic                  w_nx_commit_err;

   logic                  w_accept;
   logic                  w_fault;
   logic [SHAMT_W-1:0]    w_shamt;
   logic [XLEN-1:0]       w_lane;
   logic [XLEN-1:0]       w_load_data;

   assign in_ready = (r_state == S_IDLE) | (r_state == S_WRITE);
   assign w_accept = in_valid & in_ready;

   // Load misalignment / illegal size check on the incoming address.
   always_comb begin
      w_fault = 1'b0;
      case (in_funct3)
         3'b001, 3'b101: w_fault = in_result[0];
         3'b010, 3'b110: w_fault = |in_result[1:0];
         3'b011:         w_fault = |in_result[OFF_W-1:0];
         3'b111:         w_fault = 1'b1;
         default:        w_fault = 1'b0;
      endcase
   end

   // Shift the addressed lane of the response down to bit 0.
   assign w_shamt = SHAMT_W'({r_result[OFF_W-1:0], 3'b000});
   assign w_lane  = mem_resp_data >> w_shamt;

   // Sign- or zero-extend the selected lane according to the load size.
   always_comb begin
      w_load_data = '0;
      case (r_funct3)
         3'b000:  w_load_data = {{(XLEN-8){w_lane[7]}},   w_lane[7:0]};
         3'b001:  w_load_data = {{(XLEN-16){w_lane[15]}}, w_lane[15:0]};
         3'b010:  w_load_data = {{(XLEN-32){w_lane[31]}}, w_lane[31:0]};
         3'b011:  w_load_data = w_lane;
         3'b100:  w_load_data = {{(XLEN-8){1'b0}},  w_lane[7:0]};
         3'b101:  w_load_data = {{(XLEN-16){1'b0}}, w_lane[15:0]};
         3'b110:  w_load_data = {{(XLEN-32){1'b0}}, w_lane[31:0]};
         default: w_load_data = '0;
      endcase
   end

   // Next-state, capture and registered-output decode.
   always_comb begin
      w_next_state = r_state;
      w_nx_pc      = r_pc;
      w_nx_rd      = r_rd;
      w_nx_rd_wen  = r_rd_wen;
      w_nx_is_load = r_is_load;
      w_nx_funct3  = r_funct3;
      w_nx_result  = r_result;
      w_nx_data    = r_data;
      w_nx_err     = r_err;

      case (r_state)
         S_IDLE, S_WRITE: begin
            if (w_accept) begin
               w_nx_pc      = in_pc;
               w_nx_rd      = in_rd;
               w_nx_rd_wen  = in_rd_wen;
               w_nx_is_load = in_is_load;
               w_nx_funct3  = in_funct3;
               w_nx_result  = in_result;
               if (!in_is_load) begin
                  w_next_state = S_WRITE;
                  w_nx_data    = in_result;
                  w_nx_err     = 1'b0;
               end else if (w_fault) begin
                  w_next_state = S_WRITE;
                  w_nx_data    = '0;
                  w_nx_err     = 1'b1;
               end else begin
                  w_next_state = S_REQ;
                  w_nx_data    = '0;
                  w_nx_err     = 1'b0;
               end
            end else begin
               w_next_state = S_IDLE;
            end
         end
         S_REQ: begin
            if (mem_req_ready) w_next_state = S_WAIT;
         end
         S_WAIT: begin
            if (mem_resp_valid && r_is_load) begin
               w_nx_data    = w_load_data;
               w_next_state = S_WRITE;
            end
         end
         default: w_next_state = S_IDLE;
      endcase

      // Output values for the cycle after this edge; all zero outside their state.
      w_nx_mem_req_valid = (w_next_state == S_REQ);
      w_nx_mem_addr      = '0;
      if (w_next_state == S_REQ) w_nx_mem_addr = {w_nx_result[XLEN-1:OFF_W], {OFF_W{1'b0}}};

      w_nx_pend_valid = (w_next_state != S_IDLE);
      w_nx_pend_rd    = '0;
      if (w_next_state != S_IDLE) w_nx_pend_rd = w_nx_rd;

      w_nx_commit_valid = 1'b0;
      w_nx_commit_pc    = '0;
      w_nx_commit_err   = 1'b0;
      w_nx_rf_wen       = 1'b0;
      w_nx_rf_waddr     = '0;
      w_nx_rf_wdata     = '0;
      if (w_next_state == S_WRITE) begin
         w_nx_commit_valid = 1'b1;
         w_nx_commit_pc    = w_nx_pc;
         w_nx_commit_err   = w_nx_err;
         w_nx_rf_wen       = w_nx_rd_wen & (w_nx_rd != '0) & ~w_nx_err;
         w_nx_rf_waddr     = w_nx_rd;
         w_nx_rf_wdata     = w_nx_data;
      end
   end

   // State, captured fields and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state         <= S_IDLE;
         r_pc            <= '0;
         r_rd            <= '0;
         r_rd_wen        <= 1'b0;
         r_is_load       <= 1'b0;
         r_funct3        <= '0;
         r_result        <= '0;
         r_data          <= '0;
         r_err           <= 1'b0;
         r_mem_req_valid <= 1'b0;
         r_mem_addr      <= '0;
         r_rf_wen        <= 1'b0;
         r_rf_waddr      <= '0;
         r_rf_wdata      <= '0;
         r_pend_valid    <= 1'b0;
         r_pend_rd       <= '0;
         r_commit_valid  <= 1'b0;
         r_commit_pc     <= '0;
         r_commit_err    <= 1'b0;
      end else begin
         r_state         <= w_next_state;
         r_pc            <= w_nx_pc;
         r_rd            <= w_nx_rd;
         r_rd_wen        <= w_nx_rd_wen;
         r_is_load       <= w_nx_is_load;
         r_funct3        <= w_nx_funct3;
         r_result        <= w_nx_result;
         r_data          <= w_nx_data;
         r_err           <= w_nx_err;
         r_mem_req_valid <= w_nx_mem_req_valid;
         r_mem_addr      <= w_nx_mem_addr;
         r_rf_wen        <= w_nx_rf_wen;
         r_rf_waddr      <= w_nx_rf_waddr;
         r_rf_wdata      <= w_nx_rf_wdata;
         r_pend_valid    <= w_nx_pend_valid;
         r_pend_rd       <= w_nx_pend_rd;
         r_commit_valid  <= w_nx_commit_valid;
         r_commit_pc     <= w_nx_commit_pc;
         r_commit_err    <= w_nx_commit_err;
      end
   end

   assign mem_req_valid = r_mem_req_valid;
   assign mem_addr      = r_mem_addr;
   assign rf_wen        = r_rf_wen;
   assign rf_waddr      = r_rf_waddr;
   assign rf_wdata      = r_rf_wdata;
   assign pend_valid    = r_pend_valid;
   assign pend_rd       = r_pend_rd;
   assign commit_valid  = r_commit_valid;
   assign commit_pc     = r_commit_pc;
   assign commit_err    = r_commit_err;

endmodule

// File: tb/tb_wb_unit.sv
// tb_wb_unit: scoreboard bench for wb_unit with a simple stalling memory model.
module tb_wb_unit;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_pc;
   logic [4:0]  in_rd;
   logic        in_rd_wen;
   logic        in_is_load;
   logic [2:0]  in_funct3;
   logic [63:0] in_result;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [63:0] mem_addr;
   logic        mem_resp_valid;
   logic [63:0] mem_resp_data;
   logic        rf_wen;
   logic [4:0]  rf_waddr;
   logic [63:0] rf_wdata;
   logic        pend_valid;
   logic [4:0]  pend_rd;
   logic        commit_valid;
   logic [63:0] commit_pc;
   logic        commit_err;

   wb_unit #(.XLEN(64), .ADDR_WIDTH(5)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_rd(in_rd),
      .in_rd_wen(in_rd_wen), .in_is_load(in_is_load), .in_funct3(in_funct3),
      .in_result(in_result),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
      .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .pend_valid(pend_valid), .pend_rd(pend_rd),
      .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_err(commit_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] pc;
      logic [4:0]  rd;
      bit          wen;
      logic [63:0] data;
      bit          err;
   } sb_t;

   sb_t sb[$];
   sb_t e;

   int n_checks  = 0;
   int n_errs    = 0;
   int n_commits = 0;
   int req_count = 0;
   int resp_count = 0;

   // Memory model configuration, set by the stimulus.
   int          cfg_stall = 0;
   int          cfg_lat   = 0;
   logic [63:0] mem_rdata = '0;
   logic [63:0] exp_addr  = '0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference load extraction: gather bytes, then extend.
   function automatic logic [63:0] ld_model(input logic [2:0] f3, input logic [63:0] addr,
                                            input logic [63:0] d);
      int n;
      int off;
      logic [63:0] r;
      off = int'(addr[2:0]);
      case (f3[1:0])
         2'd0:    n = 1;
         2'd1:    n = 2;
         2'd2:    n = 4;
         default: n = 8;
      endcase
      r = '0;
      for (int i = 0; i < 8; i++)
         if (i < n && off + i < 8) r[i*8 +: 8] = d[(off+i)*8 +: 8];
      if (!f3[2] && n < 8 && r[n*8-1])
         for (int i = 0; i < 64; i++) if (i >= n*8) r[i] = 1'b1;
      return r;
   endfunction

   function automatic bit fault_model(input logic [2:0] f3, input logic [63:0] addr);
      if (f3 == 3'd7) return 1'b1;
      case (f3[1:0])
         2'd1:    return addr[0] != 1'b0;
         2'd2:    return addr[1:0] != 2'b00;
         2'd3:    return addr[2:0] != 3'b000;
         default: return 1'b0;
      endcase
   endfunction

   // Memory: holds ready low cfg_stall cycles, answers cfg_lat cycles after the handshake.
   initial begin
      int stall_cnt;
      int lat_cnt;
      bit pending;
      stall_cnt = 0; lat_cnt = 0; pending = 0;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
      forever begin
         @(negedge clk);
         mem_resp_valid = 1'b0;
         mem_resp_data  = '0;
         if (pending) begin
            if (lat_cnt == 0) begin
               mem_resp_valid = 1'b1;
               mem_resp_data  = mem_rdata;
               pending = 0;
               resp_count++;
            end else lat_cnt--;
         end
         mem_req_ready = 1'b0;
         if (rst_n && mem_req_valid && !pending) begin
            check("mem_addr", mem_addr, exp_addr);
            if (stall_cnt < cfg_stall) stall_cnt++;
            else begin
               mem_req_ready = 1'b1;
               pending = 1; lat_cnt = cfg_lat; stall_cnt = 0;
               req_count++;
            end
         end
      end
   end

   // Commit monitor: every retirement pops and compares one scoreboard entry.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (rf_wen && !commit_valid) check("wen_no_commit", 64'(rf_wen), 64'd0);
            if (commit_valid) begin
               n_commits++;
               if (sb.size() == 0) check("unexp_commit", 64'(commit_valid), 64'd0);
               else begin
                  e = sb.pop_front();
                  check("commit_pc", commit_pc, e.pc);
                  check("commit_err", 64'(commit_err), 64'(e.err));
                  check("rf_wen", 64'(rf_wen), 64'(e.wen));
                  if (e.wen) begin
                     check("rf_waddr", 64'(rf_waddr), 64'(e.rd));
                     check("rf_wdata", rf_wdata, e.data);
                  end
               end
            end
         end
      end
   end

   // Present one instruction and hold it until accepted; the expectation is queued first.
   task automatic send(input logic [63:0] pc, input logic [4:0] rd, input bit wen, input bit ld,
                       input logic [2:0] f3, input logic [63:0] res,
                       input logic [63:0] exp_data, input bit exp_err);
      sb_t x;
      bit done;
      x.pc = pc; x.rd = rd; x.err = exp_err; x.data = exp_data;
      x.wen = wen && (rd != 5'd0) && !exp_err;
      sb.push_back(x);
      in_valid = 1'b1; in_pc = pc; in_rd = rd; in_rd_wen = wen;
      in_is_load = ld; in_funct3 = f3; in_result = res;
      done = 0;
      for (int k = 0; k < 50 && !done; k++) begin
         if (in_ready) done = 1;
         @(posedge clk); #1;
      end
      if (!done) check("accept_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
   endtask

   // Wait until the scoreboard is empty and nothing is held.
   task automatic drain();
      bit done;
      done = 0;
      for (int k = 0; k < 80 && !done; k++) begin
         if (sb.size() == 0 && !pend_valid) done = 1;
         else begin @(posedge clk); #1; end
      end
      if (!done) check("drain_timeout", 64'(sb.size()), 64'd0);
   endtask

   initial begin
      logic [63:0] pc;
      logic [63:0] a;
      logic [63:0] d;
      logic [2:0]  f3;
      logic [4:0]  rd;
      bit          ld;
      bit          wen;
      bit          flt;
      int          c0;
      int          r0;

      rst_n = 1'b0; in_valid = 1'b0; in_pc = '0; in_rd = '0; in_rd_wen = 1'b0;
      in_is_load = 1'b0; in_funct3 = '0; in_result = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_rf_wen", 64'(rf_wen), 64'd0);
      check("rst_commit", 64'(commit_valid), 64'd0);
      check("rst_req", 64'(mem_req_valid), 64'd0);
      check("rst_pend", 64'(pend_valid), 64'd0);
      check("rst_wdata", rf_wdata, 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("idle_ready", 64'(in_ready), 64'd1);

      // ALU back-to-back: one write per cycle, accept never stalls.
      send(64'h100, 5'd5, 1, 0, 3'd0, 64'h11, 64'h11, 0);
      check("b2b_ready", 64'(in_ready), 64'd1);
      check("b2b_wen0", 64'(rf_wen), 64'd1);
      check("b2b_waddr0", 64'(rf_waddr), 64'd5);
      send(64'h104, 5'd6, 1, 0, 3'd0, 64'h22, 64'h22, 0);
      check("b2b_wen1", 64'(rf_wen), 64'd1);
      check("b2b_waddr1", 64'(rf_waddr), 64'd6);
      drain();

      // LB / LBU from byte 3.
      cfg_stall = 0; cfg_lat = 0;
      exp_addr = 64'h1000; mem_rdata = 64'h0000_0000_8000_0000;
      send(64'h200, 5'd7, 1, 1, 3'd0, 64'h1003, 64'hFFFF_FFFF_FFFF_FF80, 0);
      check("lb_pend_rd", 64'(pend_rd), 64'd7);
      drain();
      send(64'h204, 5'd8, 1, 1, 3'd4, 64'h1003, 64'h80, 0);
      drain();

      // LW with a stalled request and a delayed response.
      c0 = n_commits;
      cfg_stall = 3; cfg_lat = 2;
      exp_addr = 64'h2000; mem_rdata = 64'h7FFF_FFFF_0000_0000;
      send(64'h300, 5'd9, 1, 1, 3'd2, 64'h2004, 64'h0000_0000_7FFF_FFFF, 0);
      drain();
      check("lw_commits", 64'(n_commits - c0), 64'd1);

      // Misaligned LD: no request, error commit, no write.
      r0 = req_count;
      send(64'h400, 5'd10, 1, 1, 3'd3, 64'h3002, 64'h0, 1);
      drain();
      check("ld_fault_noreq", 64'(req_count - r0), 64'd0);

      // ALU to x0: commits without a write.
      send(64'h500, 5'd0, 1, 0, 3'd0, 64'h55, 64'h55, 0);
      drain();

      // Mixed random loads and ALU ops.
      pc = 64'h1000_0000;
      for (int i = 0; i < 16; i++) begin
         ld  = 1'($urandom_range(0, 1));
         f3  = 3'($urandom_range(0, 7));
         rd  = 5'($urandom_range(0, 31));
         wen = 1'($urandom_range(0, 1));
         a   = {32'h0, 32'($urandom)};
         d   = {32'($urandom), 32'($urandom)};
         cfg_stall = $urandom_range(0, 2);
         cfg_lat   = $urandom_range(0, 2);
         exp_addr  = {a[63:3], 3'b000};
         mem_rdata = d;
         flt = ld && fault_model(f3, a);
         if (!ld) send(pc, rd, wen, 0, f3, a, a, 0);
         else     send(pc, rd, wen, 1, f3, a, flt ? 64'h0 : ld_model(f3, a, d), flt);
         drain();
         pc = pc + 64'd4;
      end

      // Reset while waiting for a response, then let the stale response arrive.
      cfg_stall = 0; cfg_lat = 8;
      exp_addr = 64'h6000; mem_rdata = 64'h1234;
      c0 = n_commits; r0 = resp_count;
      send(64'h600, 5'd11, 1, 1, 3'd3, 64'h6000, 64'h1234, 0);
      @(posedge clk); #1;
      check("wait_pend", 64'(pend_valid), 64'd1);
      check("wait_noreq", 64'(mem_req_valid), 64'd0);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_pend", 64'(pend_valid), 64'd0);
      check("mid_rst_commit", 64'(commit_valid), 64'd0);
      check("mid_rst_wen", 64'(rf_wen), 64'd0);
      check("mid_rst_ready", 64'(in_ready), 64'd1);
      sb.delete();
      @(posedge clk); #3 rst_n = 1'b1;
      repeat (14) @(posedge clk);
      #1;
      check("stray_resp_seen", 64'(resp_count - r0), 64'd1);
      check("post_rst_commits", 64'(n_commits - c0), 64'd0);
      check("post_rst_pend", 64'(pend_valid), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
